// File: rtl/ctrl_decode_stage_pkg.sv
// Shared definitions for the decode stage: RV32I opcodes, control encodings,
// the registered control bundle and the branch-condition helper.
package ctrl_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        alu_a_src;
        result_src_e result_src;
        imm_src_e    imm_src;
        alu_op_e     alu_op;
        logic        branch;
        logic        jal;
        logic        jalr;
    } ctrl_bundle_t;

    // funct3 010/011 never reach here as a branch; they decode as illegal.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic eq, input logic lt,
                                          input logic ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Bundle of the upstream handshake, downstream decoded outputs and branch
// flags; the stage is the slave, its environment the master.
interface ctrl_decode_stage_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ILL_CNT_WIDTH = 8
);
    logic                     valid_i;
    logic                     ready_o;
    logic [31:0]              instr_i;
    logic [ADDR_WIDTH-1:0]    pc_i;
    logic                     flush_i;
    logic                     ready_i;
    logic                     valid_o;
    logic [ADDR_WIDTH-1:0]    pc_o;
    logic [4:0]               rd_o;
    logic [4:0]               rs1_o;
    logic [4:0]               rs2_o;
    logic                     reg_write_o;
    logic                     mem_write_o;
    logic                     alu_src_o;
    logic                     alu_a_src_o;
    logic [1:0]               result_src_o;
    logic [2:0]               imm_src_o;
    logic [1:0]               alu_op_o;
    logic                     eq_i;
    logic                     lt_i;
    logic                     ltu_i;
    logic                     pc_src_o;
    logic                     jalr_pc_src_o;
    logic                     illegal_o;
    logic [ILL_CNT_WIDTH-1:0] ill_cnt_o;

    modport slave (
        input  valid_i, instr_i, pc_i, flush_i, ready_i, eq_i, lt_i, ltu_i,
        output ready_o, valid_o, pc_o, rd_o, rs1_o, rs2_o,
               reg_write_o, mem_write_o, alu_src_o, alu_a_src_o,
               result_src_o, imm_src_o, alu_op_o,
               pc_src_o, jalr_pc_src_o, illegal_o, ill_cnt_o
    );

    modport master (
        output valid_i, instr_i, pc_i, flush_i, ready_i, eq_i, lt_i, ltu_i,
        input  ready_o, valid_o, pc_o, rd_o, rs1_o, rs2_o,
               reg_write_o, mem_write_o, alu_src_o, alu_a_src_o,
               result_src_o, imm_src_o, alu_op_o,
               pc_src_o, jalr_pc_src_o, illegal_o, ill_cnt_o
    );

endinterface

// File: rtl/ctrl_decode_stage_opcode_decode.sv
// Purely combinational RV32I opcode/funct3 decode into the control bundle,
// with an illegal flag for unlisted opcodes and reserved branch funct3.
module ctrl_opcode_decode
    import ctrl_decode_stage_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr_i[6:0];
    assign funct3            = instr_i[14:12];
    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

    // Illegal encodings leave the all-zero default bundle in place.
    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OPC_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OPC_IARITH: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OPC_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.imm_src   = IMM_S;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal_o = 1'b1;
                end else begin
                    ctrl_o.imm_src = IMM_B;
                    ctrl_o.alu_op  = ALU_BRANCH;
                    ctrl_o.branch  = 1'b1;
                end
            end
            OPC_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.jal        = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.jalr       = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_a_src = 1'b1;
                ctrl_o.imm_src   = IMM_U;
            end
            OPC_LUI: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_IMM;
                ctrl_o.imm_src    = IMM_U;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode pipeline stage: one-entry valid/ready register holding the decoded
// control bundle, branch resolution against comparator flags, illegal counter.
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int ILL_CNT_WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    ctrl_decode_stage_if.slave bus
);

    ctrl_bundle_t             dec_ctrl;
    logic                     dec_illegal;
    logic                     ready;
    logic                     accept;
    logic                     load;

    logic                     valid_q;
    ctrl_bundle_t             ctrl_q;
    logic [2:0]               funct3_q;
    logic                     illegal_q;
    logic [ADDR_WIDTH-1:0]    pc_q;
    logic [4:0]               rd_q;
    logic [4:0]               rs1_q;
    logic [4:0]               rs2_q;
    logic [ILL_CNT_WIDTH-1:0] ill_cnt_q;
    logic [ILL_CNT_WIDTH-1:0] ill_cnt_d;

    ctrl_opcode_decode u_decode (
        .instr_i   (bus.instr_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign ready  = !valid_q || bus.ready_i;
    assign accept = bus.valid_i && ready;
    assign load   = accept && !bus.flush_i;

    // An offered illegal instruction is counted even if a flush kills it.
    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (accept && dec_illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            funct3_q  <= '0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            ill_cnt_q <= '0;
        end else begin
            ill_cnt_q <= ill_cnt_d;
            if (bus.flush_i) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q   <= 1'b1;
                ctrl_q    <= dec_ctrl;
                funct3_q  <= bus.instr_i[14:12];
                illegal_q <= dec_illegal;
                pc_q      <= bus.pc_i;
                rd_q      <= bus.instr_i[11:7];
                rs1_q     <= bus.instr_i[19:15];
                rs2_q     <= bus.instr_i[24:20];
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_o       = ready;
    assign bus.valid_o       = valid_q;
    assign bus.pc_o          = pc_q;
    assign bus.rd_o          = rd_q;
    assign bus.rs1_o         = rs1_q;
    assign bus.rs2_o         = rs2_q;
    assign bus.reg_write_o   = ctrl_q.reg_write;
    assign bus.mem_write_o   = ctrl_q.mem_write;
    assign bus.alu_src_o     = ctrl_q.alu_src;
    assign bus.alu_a_src_o   = ctrl_q.alu_a_src;
    assign bus.result_src_o  = ctrl_q.result_src;
    assign bus.imm_src_o     = ctrl_q.imm_src;
    assign bus.alu_op_o      = ctrl_q.alu_op;
    assign bus.illegal_o     = illegal_q;
    assign bus.ill_cnt_o     = ill_cnt_q;

    // Redirects are resolved late, against flags for the held instruction.
    assign bus.pc_src_o      = valid_q && (ctrl_q.jal ||
                               (ctrl_q.branch &&
                                branch_taken(funct3_q, bus.eq_i, bus.lt_i, bus.ltu_i)));
    assign bus.jalr_pc_src_o = valid_q && ctrl_q.jalr;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed checks followed by a randomized run scored against a behavioural
// model of the decode stage through an expected-bundle queue.
module tb_ctrl_decode_stage;

    localparam int AW = 32;
    localparam int CW = 2;

    localparam int K_LOAD = 0, K_R = 1, K_IAR = 2, K_S = 3, K_B = 4,
                   K_JAL = 5, K_JALR = 6, K_AUIPC = 7, K_LUI = 8,
                   K_ILLOP = 9, K_ILLB = 10;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          kind;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   scoreboardOn;
    exp_t expQ[$];
    logic modelValid, nextValid;
    int   modelCnt, nextCnt;
    bit   dropHeld;

    ctrl_decode_stage_if #(.ADDR_WIDTH(AW), .ILL_CNT_WIDTH(CW)) bus ();

    ctrl_decode_stage #(.ADDR_WIDTH(AW), .ILL_CNT_WIDTH(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic fl,
                                 input logic rdy);
        bus.valid_i = v;
        bus.instr_i = ins;
        bus.pc_i    = pc;
        bus.flush_i = fl;
        bus.ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit listedOpcode(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
                          7'b0110111};
    endfunction

    // Expected {reg_write, mem_write, alu_src, alu_a_src, result_src, imm_src, alu_op}
    function automatic logic [11:0] ctrlFor(input int kind);
        case (kind)
            K_LOAD:  return {4'b1010, 2'b01, 3'b000, 2'b00};
            K_R:     return {4'b1000, 2'b00, 3'b000, 2'b10};
            K_IAR:   return {4'b1010, 2'b00, 3'b000, 2'b10};
            K_S:     return {4'b0110, 2'b00, 3'b001, 2'b00};
            K_B:     return {4'b0000, 2'b00, 3'b010, 2'b01};
            K_JAL:   return {4'b1010, 2'b10, 3'b011, 2'b00};
            K_JALR:  return {4'b1010, 2'b10, 3'b000, 2'b00};
            K_AUIPC: return {4'b1011, 2'b00, 3'b100, 2'b00};
            K_LUI:   return {4'b1010, 2'b11, 3'b100, 2'b00};
            default: return 12'b0;
        endcase
    endfunction

    function automatic bit takenRef(input logic [2:0] f3, input logic eq,
                                    input logic lt, input logic ltu);
        case (f3)
            3'd0: return eq == 1'b1;
            3'd1: return eq == 1'b0;
            3'd4: return lt == 1'b1;
            3'd5: return lt == 1'b0;
            3'd6: return ltu == 1'b1;
            3'd7: return ltu == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] makeInstr(input int kind);
        logic [31:0] r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [2:0]  legalF3 [6];
        legalF3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r  = $urandom;
        f3 = r[14:12];
        case (kind)
            K_LOAD:  op = 7'b0000011;
            K_R:     op = 7'b0110011;
            K_IAR:   op = 7'b0010011;
            K_S:     op = 7'b0100011;
            K_B:     begin op = 7'b1100011; f3 = legalF3[$urandom_range(0, 5)]; end
            K_JAL:   op = 7'b1101111;
            K_JALR:  op = 7'b1100111;
            K_AUIPC: op = 7'b0010111;
            K_LUI:   op = 7'b0110111;
            K_ILLB:  begin op = 7'b1100011; f3 = {2'b01, r[12]}; end
            default: begin
                op = r[6:0];
                while (listedOpcode(op)) op = 7'($urandom);
            end
        endcase
        return {r[31:15], f3, r[11:7], op};
    endfunction

    // Monitor: compares the held bundle against the queue head, pops on transfer
    always @(negedge clk) begin
        if (scoreboardOn) begin
            checkOutput("sb_valid", bus.valid_o, modelValid);
            checkOutput("sb_ready", bus.ready_o, !modelValid || bus.ready_i);
            checkOutput("sb_ill_cnt", bus.ill_cnt_o, modelCnt);
            if (bus.valid_o) begin
                checkOutput("sb_depth", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    exp_t e;
                    e = expQ[0];
                    checkOutput("sb_pc", bus.pc_o, e.pc);
                    checkOutput("sb_rd", bus.rd_o, e.instr[11:7]);
                    checkOutput("sb_rs1", bus.rs1_o, e.instr[19:15]);
                    checkOutput("sb_rs2", bus.rs2_o, e.instr[24:20]);
                    checkOutput("sb_ctrl", {bus.reg_write_o, bus.mem_write_o, bus.alu_src_o,
                                            bus.alu_a_src_o, bus.result_src_o, bus.imm_src_o,
                                            bus.alu_op_o}, ctrlFor(e.kind));
                    checkOutput("sb_illegal", bus.illegal_o, e.kind >= K_ILLOP);
                    checkOutput("sb_pc_src", bus.pc_src_o,
                                (e.kind == K_JAL) || (e.kind == K_B &&
                                takenRef(e.instr[14:12], bus.eq_i, bus.lt_i, bus.ltu_i)));
                    checkOutput("sb_jalr", bus.jalr_pc_src_o, e.kind == K_JALR);
                    if (bus.ready_i) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] blt, bgeu, lui, jal;
        blt  = {7'b0, 5'd2, 5'd1, 3'b100, 5'b0, 7'b1100011};
        bgeu = {7'b0, 5'd2, 5'd1, 3'b111, 5'b0, 7'b1100011};
        lui  = {20'h12345, 5'd5, 7'b0110111};
        jal  = 32'h008000EF;
        checks = 0;
        failures = 0;
        scoreboardOn = 1'b0;
        rst_n = 1'b0;
        bus.eq_i = 1'b0;
        bus.lt_i = 1'b0;
        bus.ltu_i = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", bus.valid_o, 0);
        checkOutput("rst_ill_cnt", bus.ill_cnt_o, 0);
        checkOutput("rst_pc", bus.pc_o, 0);
        checkOutput("rst_ctrl", {bus.reg_write_o, bus.mem_write_o, bus.alu_src_o,
                                 bus.result_src_o, bus.alu_op_o, bus.illegal_o}, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] addi decode");
        applyStimulus(1, 32'h00500093, 32'h100, 0, 1);
        tick();
        checkOutput("addi_valid", bus.valid_o, 1);
        checkOutput("addi_reg_write", bus.reg_write_o, 1);
        checkOutput("addi_alu_src", bus.alu_src_o, 1);
        checkOutput("addi_alu_op", bus.alu_op_o, 2'b10);
        checkOutput("addi_rd", bus.rd_o, 1);
        checkOutput("addi_pc", bus.pc_o, 32'h100);

        $display("[TB] branch resolution");
        applyStimulus(1, blt, 32'h104, 0, 1);
        tick();
        bus.lt_i = 1'b1;
        #1 checkOutput("blt_taken", bus.pc_src_o, 1);
        bus.lt_i = 1'b0;
        #1 checkOutput("blt_not_taken", bus.pc_src_o, 0);
        checkOutput("blt_ctrl", {bus.imm_src_o, bus.alu_op_o, bus.reg_write_o}, {3'b010, 2'b01, 1'b0});
        applyStimulus(1, bgeu, 32'h108, 0, 1);
        bus.ltu_i = 1'b0;
        tick();
        checkOutput("bgeu_taken", bus.pc_src_o, 1);
        bus.ltu_i = 1'b1;
        #1 checkOutput("bgeu_not_taken", bus.pc_src_o, 0);
        checkOutput("bgeu_jalr", bus.jalr_pc_src_o, 0);

        $display("[TB] backpressure");
        applyStimulus(1, lui, 32'h10C, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stall_ready", bus.ready_o, 0);
            checkOutput("stall_pc", bus.pc_o, 32'h108);
            checkOutput("stall_imm_src", bus.imm_src_o, 3'b010);
        end
        bus.ready_i = 1'b1;
        #1 checkOutput("unstall_ready", bus.ready_o, 1);
        tick();
        checkOutput("lui_pc", bus.pc_o, 32'h10C);
        checkOutput("lui_result_src", bus.result_src_o, 2'b11);
        checkOutput("lui_rd", bus.rd_o, 5);

        $display("[TB] flush");
        applyStimulus(1, jal, 32'h110, 1, 1);
        tick();
        checkOutput("flush_valid", bus.valid_o, 0);
        checkOutput("flush_pc_src", bus.pc_src_o, 0);
        checkOutput("flush_ill_cnt", bus.ill_cnt_o, 0);

        $display("[TB] illegal counter saturation");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 32'h00000080, 32'h200 + 32'(4 * i), 0, 1);
            tick();
            checkOutput("ill_flag", bus.illegal_o, 1);
            checkOutput("ill_cnt", bus.ill_cnt_o, (i > 3) ? 3 : i);
            checkOutput("ill_writes", {bus.reg_write_o, bus.mem_write_o}, 0);
            checkOutput("ill_valid", bus.valid_o, 1);
        end

        $display("[TB] asynchronous reset");
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", bus.valid_o, 0);
        checkOutput("arst_ill_cnt", bus.ill_cnt_o, 0);
        checkOutput("arst_illegal", bus.illegal_o, 0);
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(1, 32'h00500093, 32'h300, 0, 1);
        tick();
        checkOutput("post_rst_load", bus.valid_o, 1);

        $display("[TB] randomized run");
        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        modelValid = 1'b0;
        nextValid  = 1'b0;
        modelCnt   = 0;
        nextCnt    = 0;
        dropHeld   = 1'b0;
        scoreboardOn = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic v, fl, rdy, readyModel;
            int   kind;
            logic [31:0] ins, pc;
            modelValid = nextValid;
            modelCnt   = nextCnt;
            if (dropHeld) begin
                void'(expQ.pop_front());
                dropHeld = 1'b0;
            end
            kind = $urandom_range(0, 10);
            ins  = makeInstr(kind);
            pc   = $urandom & 32'hFFFF_FFFC;
            if (cyc < 2990) begin
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 7);
                fl  = ($urandom_range(0, 9) == 0);
            end else begin
                v = 1'b0; rdy = 1'b1; fl = 1'b0;
            end
            applyStimulus(v, ins, pc, fl, rdy);
            bus.eq_i  = 1'($urandom);
            bus.lt_i  = 1'($urandom);
            bus.ltu_i = 1'($urandom);
            readyModel = !modelValid || rdy;
            if (v && readyModel && kind >= K_ILLOP && modelCnt < (1 << CW) - 1)
                nextCnt = modelCnt + 1;
            if (fl) begin
                if (modelValid && !rdy) dropHeld = 1'b1;
                nextValid = 1'b0;
            end else if (v && readyModel) begin
                expQ.push_back('{instr: ins, pc: pc, kind: kind});
                nextValid = 1'b1;
            end else if (rdy) begin
                nextValid = 1'b0;
            end
            tick();
        end
        scoreboardOn = 1'b0;
        checkOutput("sb_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of carried PC.
REQ-002 Parameter ILL_CNT_WIDTH, default 8, width of saturating illegal-instruction counter.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  upstream instruction valid; ready_o  out  1  stage can accept.
REQ-006 instr_i  in  32  RV32I instruction; pc_i  in  ADDR_WIDTH  its PC.
REQ-007 flush_i  in  1  kill held instruction and any same-cycle load.
REQ-008 ready_i  in  1  downstream accept; valid_o  out  1  registered bundle valid.
REQ-009 pc_o  out  ADDR_WIDTH; rd_o, rs1_o, rs2_o  out  5  registered fields.
REQ-010 reg_write_o, mem_write_o, alu_src_o, alu_a_src_o (1 = PC)  out  1 each; result_src_o  out  2  (00 ALU, 01 mem, 10 PC+4, 11 imm); imm_src_o  out  3  (000 I, 001 S, 010 B, 011 J, 100 U); alu_op_o  out  2  (00 add, 01 branch, 10 funct-decoded).
REQ-011 eq_i, lt_i, ltu_i  in  1 each  comparator flags for held instruction.
REQ-012 pc_src_o  out  1  take immediate target; jalr_pc_src_o  out  1  take register target.
REQ-013 illegal_o  out  1  held instruction illegal; ill_cnt_o  out  ILL_CNT_WIDTH.

Function
REQ-014 Handshake: ready_o = !valid_o || ready_i; load occurs when valid_i && ready_o && !flush_i; latency one cycle.
REQ-015 On load: valid_o <= 1, all control, fields, pc_o registered from instr_i/pc_i.
REQ-016 No load and ready_i: valid_o <= 0; no load and !ready_i: all registers hold.
REQ-017 flush_i: valid_o <= 0 next cycle regardless of valid_i/ready_i; flush has priority over load.
REQ-018 Opcode map (reg_write, mem_write, alu_src, alu_a_src, result_src, imm_src, alu_op): load 0000011 = 1,0,1,0,01,000,00; R 0110011 = 1,0,0,0,00,000,10; I-arith 0010011 = 1,0,1,0,00,000,10; S 0100011 = 0,1,1,0,00,001,00; B 1100011 = 0,0,0,0,00,010,01; JAL 1101111 = 1,0,1,0,10,011,00; JALR 1100111 = 1,0,1,0,10,000,00; AUIPC 0010111 = 1,0,1,1,00,100,00; LUI 0110111 = 1,0,1,0,11,100,00.
REQ-019 Internal registered branch, jal, jalr, funct3 bits; branch only for B-type.
REQ-020 Branch taken by funct3: 000 eq_i, 001 !eq_i, 100 lt_i, 101 !lt_i, 110 ltu_i, 111 !ltu_i.
REQ-021 pc_src_o = valid_o && (jal || (branch && taken)); jalr_pc_src_o = valid_o && jalr; both combinational from registered state and flags.
REQ-022 Illegal: unlisted opcode, or B-type funct3 010/011; loaded with reg_write, mem_write, branch, jal, jalr all 0, other controls 0, illegal_o 1.
REQ-023 ill_cnt_o increments by 1 per loaded illegal instruction, saturates at all-ones, never wraps; flushed instructions still counted.

Reset
REQ-024 rst_n_i low: valid_o, all control outputs, fields, pc_o, illegal_o, ill_cnt_o, internal branch/jal/jalr/funct3 = 0 immediately, asynchronously.
REQ-025 Reset mid-transfer discards held instruction; first load allowed on first rising edge after release.

Structure
REQ-026 Shared package holds opcode constants, imm_src/result_src/alu_op enumerations, and the control-bundle struct.
REQ-027 One sub-module, ctrl_opcode_decode: purely combinational opcode/funct3 -> bundle plus illegal flag; ctrl_decode_stage owns registers, handshake, branch resolution, counter.

Verification
REQ-028 Reset then load addi x1,x0,5 (0x00500093) with ready_i=1 -> next cycle valid_o=1, reg_write_o=1, alu_src_o=1, alu_op_o=10, rd_o=1.
REQ-029 Load BLT (funct3 100), lt_i=1 -> pc_src_o=1; lt_i=0 -> pc_src_o=0; BGEU with ltu_i=0 -> pc_src_o=1.
REQ-030 Hold ready_i=0 two cycles with valid_i=1 -> ready_o=0, outputs unchanged; ready_i=1 -> next instruction loads.
REQ-031 flush_i=1 with valid_i=1 on JAL -> next cycle valid_o=0, pc_src_o=0, ill_cnt_o unchanged.
REQ-032 ILL_CNT_WIDTH=2, load 5 instructions with opcode 0000000 -> illegal_o=1 each, ill_cnt_o 1,2,3,3,3, reg_write_o=0, mem_write_o=0.
REQ-033 Assert rst_n_i low mid-cycle while valid_o=1 -> valid_o and ill_cnt_o 0 before next clock edge.
